// File: rtl/hazard_pkg.sv
// Shared types for the data-hazard scoreboard: the in-flight slot record
// and the forwarding-select width helper.
package hazard_pkg;

    localparam int REG_W_DEF = 3;
    localparam int DEPTH_DEF = 3;
    // Slot destination field is sized for the widest register index we support
    localparam int DST_MAX_W = 8;

    typedef struct packed {
        logic                 valid;
        logic [DST_MAX_W-1:0] dst;
        logic                 is_load;
    } slot_t;

    function automatic int fwd_sel_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/hazard_match.sv
// Priority comparator of one decode source operand against the in-flight
// slots; the youngest (lowest-index) matching writer wins.
module hazard_match
    import hazard_pkg::*;
#(
    parameter int REG_W           = REG_W_DEF,
    parameter int DEPTH           = DEPTH_DEF,
    parameter int LOAD_READY_SLOT = 2,
    parameter int IDX_W           = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  slot_t [DEPTH-1:0] slots,
    input  logic [REG_W-1:0]  src,
    input  logic              src_used,
    input  logic              id_valid,
    output logic              hit,
    output logic              ready,
    output logic [IDX_W-1:0]  index
);

    // Walk oldest to youngest so the last assignment is the youngest match
    always_comb begin
        hit   = 1'b0;
        ready = 1'b0;
        index = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (id_valid && src_used && slots[i].valid &&
                slots[i].dst == DST_MAX_W'(src)) begin
                hit   = 1'b1;
                index = IDX_W'(i);
                ready = !slots[i].is_load || (i >= LOAD_READY_SLOT);
            end
        end
    end

endmodule

// File: rtl/hazard_scoreboard.sv
// Data-hazard unit beside decode: shift scoreboard of in-flight writers,
// per-operand forwarding selects and load-use stall.
module hazard_scoreboard
    import hazard_pkg::*;
#(
    parameter int  REG_W           = REG_W_DEF,
    parameter int  NUM_SRC         = 2,
    parameter int  DEPTH           = DEPTH_DEF,
    parameter int  LOAD_READY_SLOT = 2,
    parameter int  FLUSH_SLOTS     = 1,
    localparam int SEL_W           = fwd_sel_w(DEPTH),
    localparam int IDX_W           = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     id_valid_i,
    input  logic [NUM_SRC*REG_W-1:0] id_src_i,
    input  logic [NUM_SRC-1:0]       id_src_used_i,
    input  logic                     id_wr_en_i,
    input  logic [REG_W-1:0]         id_dst_i,
    input  logic                     id_is_load_i,
    input  logic                     pipe_hold_i,
    input  logic                     flush_i,
    output logic                     stall_o,
    output logic [NUM_SRC*SEL_W-1:0] fwd_sel_o,
    output logic [15:0]              stall_cycles_o
);

    logic [DEPTH-1:0]            slot_vld;
    logic [DEPTH-1:0]            vld_nxt;
    logic [DEPTH-1:0][REG_W-1:0] slot_dst;
    logic [DEPTH-1:0]            slot_ld;
    slot_t [DEPTH-1:0]           slots;

    logic [NUM_SRC-1:0]            hit;
    logic [NUM_SRC-1:0]            ready;
    logic [NUM_SRC-1:0][IDX_W-1:0] index;

    function automatic logic [15:0] sat_inc(input logic [15:0] c);
        return (c == 16'hFFFF) ? c : c + 16'd1;
    endfunction

    always_comb begin
        slots = '0;
        for (int i = 0; i < DEPTH; i++) begin
            slots[i] = '{valid: slot_vld[i], dst: DST_MAX_W'(slot_dst[i]), is_load: slot_ld[i]};
        end
    end

    for (genvar k = 0; k < NUM_SRC; k++) begin : g_match
        hazard_match #(
            .REG_W          (REG_W),
            .DEPTH          (DEPTH),
            .LOAD_READY_SLOT(LOAD_READY_SLOT),
            .IDX_W          (IDX_W)
        ) u_match (
            .slots   (slots),
            .src     (id_src_i[k*REG_W +: REG_W]),
            .src_used(id_src_used_i[k]),
            .id_valid(id_valid_i),
            .hit     (hit[k]),
            .ready   (ready[k]),
            .index   (index[k])
        );
    end

    // Decode stage: id_valid_i is already folded into every match
    assign stall_o = |(hit & ~ready);

    always_comb begin
        fwd_sel_o = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            if (hit[k] && ready[k]) begin
                fwd_sel_o[k*SEL_W +: SEL_W] = SEL_W'(index[k]) + SEL_W'(1);
            end
        end
    end

    // Flush clears the youngest slots, post-shift or in place under hold
    always_comb begin
        vld_nxt = slot_vld;
        if (!pipe_hold_i) begin
            for (int i = DEPTH - 1; i >= 1; i--) begin
                vld_nxt[i] = slot_vld[i-1];
            end
            vld_nxt[0] = id_valid_i & id_wr_en_i & ~stall_o;
        end
        if (flush_i) begin
            for (int i = 0; i < FLUSH_SLOTS; i++) begin
                vld_nxt[i] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            slot_vld       <= '0;
            stall_cycles_o <= '0;
        end else begin
            slot_vld <= vld_nxt;
            if (stall_o && !pipe_hold_i) begin
                stall_cycles_o <= sat_inc(stall_cycles_o);
            end
        end
    end

    // Slot payload is qualified by slot_vld, so it carries no reset
    always_ff @(posedge clk) begin
        if (!pipe_hold_i) begin
            for (int i = DEPTH - 1; i >= 1; i--) begin
                slot_dst[i] <= slot_dst[i-1];
                slot_ld[i]  <= slot_ld[i-1];
            end
            slot_dst[0] <= id_dst_i;
            slot_ld[0]  <= id_is_load_i;
        end
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Scoreboard bench for hazard_scoreboard: a driver predicts each cycle's
// response from an instruction-history model; a monitor compares on negedge.
module tb_hazard_scoreboard;

    localparam int REG_W   = 3;
    localparam int NUM_SRC = 2;
    localparam int DEPTH   = 3;
    localparam int LRS     = 2;
    localparam int FS      = 1;
    localparam int SEL_W   = 2;

    logic                     clk = 1'b0;
    logic                     reset_n = 1'b0;
    logic                     id_valid_i = 1'b0;
    logic [NUM_SRC*REG_W-1:0] id_src_i = '0;
    logic [NUM_SRC-1:0]       id_src_used_i = '0;
    logic                     id_wr_en_i = 1'b0;
    logic [REG_W-1:0]         id_dst_i = '0;
    logic                     id_is_load_i = 1'b0;
    logic                     pipe_hold_i = 1'b0;
    logic                     flush_i = 1'b0;
    logic                     stall_o;
    logic [NUM_SRC*SEL_W-1:0] fwd_sel_o;
    logic [15:0]              stall_cycles_o;

    hazard_scoreboard #(
        .REG_W(REG_W), .NUM_SRC(NUM_SRC), .DEPTH(DEPTH),
        .LOAD_READY_SLOT(LRS), .FLUSH_SLOTS(FS)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .id_valid_i    (id_valid_i),
        .id_src_i      (id_src_i),
        .id_src_used_i (id_src_used_i),
        .id_wr_en_i    (id_wr_en_i),
        .id_dst_i      (id_dst_i),
        .id_is_load_i  (id_is_load_i),
        .pipe_hold_i   (pipe_hold_i),
        .flush_i       (flush_i),
        .stall_o       (stall_o),
        .fwd_sel_o     (fwd_sel_o),
        .stall_cycles_o(stall_cycles_o)
    );

    always #5 clk = ~clk;

    // History of issued instructions, youngest first (age 0 = execute)
    typedef struct {
        bit v;
        int dst;
        bit ld;
    } ent_t;

    typedef struct {
        bit                       stall;
        logic [NUM_SRC*SEL_W-1:0] fwd;
        logic [15:0]              cnt;
    } exp_t;

    ent_t mq[$];
    exp_t sbq[$];
    int   mcnt;
    int   n_checks = 0;
    int   n_pass = 0;
    exp_t me;

    task automatic model_clear();
        ent_t z;
        z = '{v: 1'b0, dst: 0, ld: 1'b0};
        mq.delete();
        repeat (DEPTH) mq.push_back(z);
        mcnt = 0;
    endtask

    task automatic step(input bit rs, input bit v, input int s0, input int s1,
                        input bit [1:0] used, input bit wr, input int dst,
                        input bit ld, input bit hold, input bit fl);
        exp_t e;
        ent_t n;
        bit   stl;
        bit   hit;
        int   idx;
        int   src;
        @(posedge clk);
        #1;
        reset_n       = !rs;
        id_valid_i    = v;
        id_src_i      = {REG_W'(s1), REG_W'(s0)};
        id_src_used_i = used;
        id_wr_en_i    = wr;
        id_dst_i      = REG_W'(dst);
        id_is_load_i  = ld;
        pipe_hold_i   = hold;
        flush_i       = fl;
        if (rs) model_clear();
        e.fwd = '0;
        stl   = 1'b0;
        for (int k = 0; k < NUM_SRC; k++) begin
            src = (k == 0) ? s0 : s1;
            hit = 1'b0;
            idx = 0;
            for (int i = 0; i < mq.size(); i++) begin
                if (!hit && v && used[k] && mq[i].v && mq[i].dst == src) begin
                    hit = 1'b1;
                    idx = i;
                end
            end
            if (hit && mq[idx].ld && idx < LRS) stl = 1'b1;
            else if (hit) e.fwd[k*SEL_W +: SEL_W] = SEL_W'(idx + 1);
        end
        e.stall = stl;
        e.cnt   = 16'(mcnt);
        sbq.push_back(e);
        if (!rs) begin
            if (!hold) begin
                n = '{v: v && wr && !stl, dst: dst, ld: ld};
                mq.push_front(n);
                void'(mq.pop_back());
                if (stl && mcnt < 65535) mcnt++;
            end
            if (fl) for (int i = 0; i < FS; i++) mq[i].v = 1'b0;
        end
    endtask

    always @(negedge clk) begin
        if (sbq.size() > 0) begin
            me = sbq.pop_front();
            n_checks++;
            if (stall_o === me.stall) n_pass++;
            else $display("FAIL stall_o: got %0b expected %0b at %0t", stall_o, me.stall, $time);
            n_checks++;
            if (stall_cycles_o === me.cnt) n_pass++;
            else $display("FAIL stall_cycles: got %0d expected %0d at %0t", stall_cycles_o, me.cnt, $time);
            if (!me.stall) begin
                for (int k = 0; k < NUM_SRC; k++) begin
                    n_checks++;
                    if (fwd_sel_o[k*SEL_W +: SEL_W] === me.fwd[k*SEL_W +: SEL_W]) n_pass++;
                    else $display("FAIL fwd_sel[%0d]: got %0d expected %0d at %0t", k,
                                  fwd_sel_o[k*SEL_W +: SEL_W], me.fwd[k*SEL_W +: SEL_W], $time);
                end
            end
        end
    end

    initial begin
        // Reset state
        step(1, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0);
        // ADD r2, dependent reader, then r2 ages through the slots
        step(0, 1, 0, 0, 2'b00, 1, 2, 0, 0, 0);
        step(0, 1, 2, 0, 2'b01, 1, 1, 0, 0, 0);
        repeat (3) step(0, 1, 2, 2, 2'b11, 0, 0, 0, 0, 0);
        // LD r3 then ADD r3: load-use stall until slot 2
        step(0, 1, 0, 0, 2'b00, 1, 3, 1, 0, 0);
        repeat (3) step(0, 1, 3, 0, 2'b01, 1, 4, 0, 0, 0);
        step(0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0);
        // ADD r4, SUB r4, ST reading r4: youngest wins
        step(0, 1, 0, 0, 2'b00, 1, 4, 0, 0, 0);
        step(0, 1, 4, 4, 2'b11, 1, 4, 0, 0, 0);
        step(0, 1, 4, 1, 2'b11, 0, 0, 0, 0, 0);
        // CALL writes r7; ST reads it, then the same with operand unused
        step(0, 1, 0, 0, 2'b00, 1, 7, 0, 0, 0);
        step(0, 1, 7, 0, 2'b01, 0, 0, 0, 0, 0);
        step(0, 1, 0, 0, 2'b00, 1, 7, 0, 0, 0);
        step(0, 1, 7, 0, 2'b00, 0, 0, 0, 0, 0);
        // LD r5 with a dependent ADD frozen by hold, then released
        step(0, 1, 0, 0, 2'b00, 1, 5, 1, 0, 0);
        repeat (3) step(0, 1, 5, 0, 2'b01, 1, 6, 0, 1, 0);
        repeat (3) step(0, 1, 5, 0, 2'b01, 1, 6, 0, 0, 0);
        // ADD r0 tracked like any register
        step(0, 1, 0, 0, 2'b00, 1, 0, 0, 0, 0);
        step(0, 1, 0, 0, 2'b11, 0, 0, 0, 0, 0);
        // ADD r6 squashed by flush; dependent reads the register file
        step(0, 1, 0, 0, 2'b00, 1, 6, 0, 0, 1);
        step(0, 1, 6, 6, 2'b11, 0, 0, 0, 0, 0);
        // Flush under hold invalidates slot 0 in place
        step(0, 1, 0, 0, 2'b00, 1, 2, 0, 0, 0);
        step(0, 0, 0, 0, 2'b00, 0, 0, 0, 1, 1);
        step(0, 1, 2, 0, 2'b01, 0, 0, 0, 0, 0);
        // Reset asserted mid-stall
        step(0, 1, 0, 0, 2'b00, 1, 6, 1, 0, 0);
        step(0, 1, 6, 0, 2'b01, 1, 1, 0, 0, 0);
        step(1, 1, 6, 0, 2'b01, 1, 1, 0, 0, 0);
        step(0, 1, 6, 0, 2'b01, 1, 1, 0, 0, 0);
        // Randomized traffic
        for (int n = 0; n < 1500; n++) begin
            step($urandom_range(0, 299) == 0,
                 $urandom_range(0, 9) != 0,
                 int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                 2'($urandom_range(0, 3)),
                 $urandom_range(0, 3) != 0,
                 int'($urandom_range(0, 7)),
                 $urandom_range(0, 2) == 0,
                 $urandom_range(0, 7) == 0,
                 $urandom_range(0, 9) == 0);
        end
        step(0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0);
        repeat (2) @(negedge clk);
        #1;
        if (sbq.size() != 0) begin
            n_checks++;
            $display("FAIL drain: %0d expectations pending, expected 0", sbq.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
